right_shift_seq: RTL

Iterative right shifter for the execute stage, the counterpart to the fixed left-shift-by-2 used for branch offsets. It covers the variable right shifts (SRL/SRLV, SRA/SRAV) and byte-address-to-word-index conversion (shift by 2), one bit position per clock. A start/busy/done handshake lets the pipeline control stall on it.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/shift_right_1.sv | 12 +
 rtl/right_shift_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: shifter state encoding, shift-kind
// selectors and the default datapath widths used by the ALU decoder.
package cpu_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/shift_right_1.sv
// Single-position right shift with a caller-supplied fill bit.
module shift_right_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    assign shifted = {fill, operand[WIDTH-1:1]};

endmodule

// File: rtl/right_shift_seq.sv
// Iterative logical/arithmetic right shifter, one bit per clock, with a
// start/busy/done handshake so the pipeline can stall on it.
module right_shift_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};

    shift_state_e       state_r, state_next_s;
    logic [WIDTH-1:0]   work_r, work_next_s, shifted_s;
    logic [SHAMT_W-1:0] cnt_r, cnt_next_s;
    logic               fill_r, fill_next_s;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   result_r;

    shift_right_1 #(.WIDTH(WIDTH)) u_shr (
        .operand (work_r),
        .fill    (fill_r),
        .shifted (shifted_s)
    );

    // Next-state, operand capture and per-cycle shift/decrement.
    always_comb begin
        state_next_s = state_r;
        work_next_s  = work_r;
        cnt_next_s   = cnt_r;
        fill_next_s  = fill_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_next_s = a;
                    cnt_next_s  = shamt;
                    // Sign fill is fixed at acceptance so later input changes cannot leak in.
                    if (arith == SHIFT_ARITH) begin
                        fill_next_s = a[WIDTH-1];
                    end else begin
                        fill_next_s = 1'b0;
                    end
                    if (shamt == CNT_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_next_s = shifted_s;
                cnt_next_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            work_r   <= {WIDTH{1'b0}};
            cnt_r    <= CNT_ZERO;
            fill_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            work_r  <= work_next_s;
            cnt_r   <= cnt_next_s;
            fill_r  <= fill_next_s;
            busy_r  <= (state_next_s == ST_SHIFT);
            done_r  <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                result_r <= work_next_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
